// File: rtl/pool_ofm_writer_if.sv
// Sample-in / OFM-write bus of the pooling write-back stage.
// slave: the writer itself; master: the controller/SRAM side.
interface pool_ofm_writer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  end_pool;
  logic                  mem_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  modport slave (
    input  in_valid, in_data, end_pool, mem_ready,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data, end_pool, mem_ready,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/pool_ofm_writer.sv
// Pooling write-back stage: elastic FIFO, channel-major OFM addressing, pass status.
// Optional POOL_WB_RELU_EN clamps negative samples to zero at push.
module pool_ofm_writer #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_POOL = 4,
  parameter int IFM_SIZE    = 9,
  parameter int STRIDE_POOL = 2,
  parameter int CI          = 3,
  parameter int ADDR_WIDTH  = 12,
  parameter int BASE_ADDR   = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk1,
  input  logic                   rst_n,
  pool_ofm_writer_if.slave       bus,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic                   count_err
);

  localparam int OFM_SIZE = (IFM_SIZE - KERNEL_POOL) / STRIDE_POOL + 1;
  localparam int TOTAL    = OFM_SIZE * OFM_SIZE * CI;
  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ROW_A    = ADDR_WIDTH'(OFM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] PLANE_A  = ADDR_WIDTH'(OFM_SIZE * OFM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] EDGE_END = ADDR_WIDTH'(OFM_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] CH_END   = ADDR_WIDTH'(CI - 1);
  localparam logic [15:0]           TOTAL_C  = 16'(TOTAL);
  localparam logic [PTR_W:0]        FULL_C   = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic                  end_pool_q;
  logic                  pool_rise;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        fifo_cnt;
  logic                  empty, full, push, pop, drop;
  logic [DATA_WIDTH-1:0] push_data;
  logic [15:0]           acc_cnt, acc_nxt;
  logic [ADDR_WIDTH-1:0] col, row, ch;
  logic                  clr_pass, set_cerr;

  assign pool_rise = bus.end_pool && !end_pool_q;
  assign empty     = (fifo_cnt == '0);
  assign full      = (fifo_cnt == FULL_C);
  assign pop       = !empty && bus.mem_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still takes the sample.
  assign push      = bus.in_valid && (!full || pop);
  assign drop      = bus.in_valid && full && !pop;
  assign acc_nxt   = (push && (acc_cnt != '1)) ? acc_cnt + 16'd1 : acc_cnt;

`ifdef POOL_WB_RELU_EN
  assign push_data = bus.in_data[DATA_WIDTH-1] ? '0 : bus.in_data;
`else
  assign push_data = bus.in_data;
`endif

  assign bus.mem_we    = !empty;
  assign bus.mem_wdata = empty ? '0 : fifo_mem[rd_ptr];
  assign bus.mem_addr  = BASE_A + ch * PLANE_A + row * ROW_A + col;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

  always_comb begin
    state_nxt = state;
    clr_pass  = 1'b0;
    set_cerr  = 1'b0;
    case (state)
      IDLE: begin
        if (pool_rise) begin
          if (bus.in_valid) begin
            state_nxt = DRAIN;
          end else begin
            state_nxt = DONE;
            set_cerr  = (TOTAL != 0);
          end
        end else if (bus.in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: if (pool_rise) state_nxt = DRAIN;
      DRAIN: begin
        // Empty FIFO means mem_we is low, so no write can fire this cycle.
        if (empty) begin
          state_nxt = DONE;
          set_cerr  = (acc_nxt != TOTAL_C);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        clr_pass  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state      <= IDLE;
      end_pool_q <= 1'b0;
      overflow   <= 1'b0;
      count_err  <= 1'b0;
      acc_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      end_pool_q <= bus.end_pool;
      if (drop)     overflow  <= 1'b1;
      if (set_cerr) count_err <= 1'b1;
      acc_cnt <= clr_pass ? '0 : acc_nxt;
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk1) begin
    if (!rst_n || clr_pass) begin
      col <= '0;
      row <= '0;
      ch  <= '0;
    end else if (pop) begin
      if (col == EDGE_END) begin
        col <= '0;
        if (row == EDGE_END) begin
          row <= '0;
          ch  <= (ch == CH_END) ? '0 : ch + 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pool_ofm_writer.sv
// Directed self-checking bench for pool_ofm_writer; a negedge monitor logs
// every accepted write and every done cycle for later comparison.
module tb_pool_ofm_writer;

  logic clk1 = 1'b0;
  logic rst_n;
  logic busy, done, overflow, count_err;

  pool_ofm_writer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(12)) bus ();

  pool_ofm_writer #(
    .DATA_WIDTH(16), .KERNEL_POOL(4), .IFM_SIZE(9), .STRIDE_POOL(2),
    .CI(3), .ADDR_WIDTH(12), .BASE_ADDR(0), .FIFO_DEPTH(4)
  ) dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .count_err (count_err)
  );

  always #5 clk1 = ~clk1;

  int unsigned cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  int unsigned log_cyc  [$];
  int unsigned done_cnt = 0;

  always @(negedge clk1) begin
    if (rst_n) begin
      if (bus.mem_we && bus.mem_ready) begin
        log_addr.push_back(32'(bus.mem_addr));
        log_data.push_back(32'(bus.mem_wdata));
        log_cyc.push_back(cyc);
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.end_pool = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drive_samples(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(base + i);
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_end();
    bus.end_pool = 1'b1;
    tick();
    bus.end_pool = 1'b0;
  endtask

  task automatic wait_done(input int unsigned target, input string tag);
    int unsigned budget = 0;
    while (done_cnt < target && budget < 60) begin
      tick();
      budget++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt), 32'(target));
    tick();
    tick();
    check({tag, "_done_once"}, 32'(done_cnt), 32'(target));
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_writes(input string tag, input int unsigned base, input int n,
                              input int addr0, input int data0);
    check({tag, "_nwrites"}, 32'(log_addr.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, log_addr[base + i], 32'(addr0 + i));
      check({tag, "_data"}, log_data[base + i], 32'(16'(data0 + i)));
    end
  endtask

  logic [15:0] relu_in  [3];
  logic [15:0] relu_exp [3];

  initial begin
    int unsigned base;
    int unsigned dbase;

    bus.mem_ready = 1'b1;
    do_reset();

    // Reset state
    check("rst_mem_we",    32'(bus.mem_we),    32'd0);
    check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_done",      32'(done),          32'd0);
    check("rst_overflow",  32'(overflow),      32'd0);
    check("rst_count_err", 32'(count_err),     32'd0);

    // Full 27-sample pass, mem_ready held high
    base  = log_addr.size();
    dbase = done_cnt;
    drive_samples(27, 0);
    pulse_end();
    wait_done(dbase + 1, "full");
    check_writes("full", base, 27, 0, 0);
    check("full_count_err", 32'(count_err), 32'd0);
    check("full_overflow",  32'(overflow),  32'd0);

    // Backpressure: 6 samples against a 4-deep FIFO
    do_reset();
    bus.mem_ready = 1'b0;
    drive_samples(6, 1);
    check("bp_overflow", 32'(overflow),      32'd1);
    check("bp_we",       32'(bus.mem_we),    32'd1);
    check("bp_addr",     32'(bus.mem_addr),  32'd0);
    check("bp_wdata",    32'(bus.mem_wdata), 32'd1);
    repeat (14) tick();
    check("bp_hold_we",    32'(bus.mem_we),    32'd1);
    check("bp_hold_addr",  32'(bus.mem_addr),  32'd0);
    check("bp_hold_wdata", 32'(bus.mem_wdata), 32'd1);
    base = log_addr.size();
    bus.mem_ready = 1'b1;
    repeat (8) tick();
    check_writes("bp", base, 4, 0, 1);
    dbase = done_cnt;
    pulse_end();
    wait_done(dbase + 1, "bp");
    check("bp_count_err", 32'(count_err), 32'd1);

    // Full FIFO with simultaneous push and pop every cycle
    do_reset();
    bus.mem_ready = 1'b0;
    drive_samples(4, 100);
    base = log_addr.size();
    bus.mem_ready = 1'b1;
    drive_samples(12, 104);
    repeat (6) tick();
    check_writes("stream", base, 16, 0, 100);
    check("stream_overflow", 32'(overflow), 32'd0);
    check("stream_rate", 32'(log_cyc[base + 15] - log_cyc[base]), 32'd15);

    // Short pass of 25 samples, then the next pass restarts at address 0
    do_reset();
    base  = log_addr.size();
    dbase = done_cnt;
    drive_samples(25, 0);
    pulse_end();
    wait_done(dbase + 1, "short");
    check_writes("short", base, 25, 0, 0);
    check("short_count_err", 32'(count_err), 32'd1);
    base = log_addr.size();
    drive_samples(2, 50);
    repeat (4) tick();
    check_writes("next", base, 2, 0, 50);

    // Reset with three entries queued
    do_reset();
    bus.mem_ready = 1'b0;
    drive_samples(3, 7);
    check("preq_busy", 32'(busy),       32'd1);
    check("preq_we",   32'(bus.mem_we), 32'd1);
    rst_n = 1'b0;
    tick();
    check("midrst_we",    32'(bus.mem_we),    32'd0);
    check("midrst_busy",  32'(busy),          32'd0);
    check("midrst_wdata", 32'(bus.mem_wdata), 32'd0);
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    tick();
    base  = log_addr.size();
    dbase = done_cnt;
    drive_samples(27, 200);
    pulse_end();
    wait_done(dbase + 1, "post");
    check_writes("post", base, 27, 0, 200);
    check("post_count_err", 32'(count_err), 32'd0);

    // end_pool edge while idle
    do_reset();
    base  = log_addr.size();
    dbase = done_cnt;
    pulse_end();
    wait_done(dbase + 1, "idle_end");
    check("idle_end_nwrites",  32'(log_addr.size() - base), 32'd0);
    check("idle_end_count_err", 32'(count_err), 32'd1);

    // Sign handling at push
    relu_in[0] = 16'hFFFB;
    relu_in[1] = 16'h0007;
    relu_in[2] = 16'h8000;
`ifdef POOL_WB_RELU_EN
    relu_exp[0] = 16'h0000;
    relu_exp[1] = 16'h0007;
    relu_exp[2] = 16'h0000;
`else
    relu_exp[0] = 16'hFFFB;
    relu_exp[1] = 16'h0007;
    relu_exp[2] = 16'h8000;
`endif
    do_reset();
    base = log_addr.size();
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = relu_in[i];
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (4) tick();
    check("sign_nwrites", 32'(log_addr.size() - base), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("sign_addr", log_addr[base + i], 32'(i));
      check("sign_data", log_data[base + i], 32'(relu_exp[i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
